// File: rtl/layer_deserializer.sv
// Collects INPUT_SIZE consecutive words from a valid/ready stream into one
// parallel vector and presents it downstream on its own valid/ready handshake.
module layer_deserializer #(
  parameter int INPUT_SIZE = 4,
  parameter int WORD_SIZE  = 16,
  localparam int CW        = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [WORD_SIZE-1:0]            data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [INPUT_SIZE*WORD_SIZE-1:0] data_o,
  output logic [CW-1:0]                   count_o
);

  typedef enum logic {
    eFILL = 1'b0,
    eFULL = 1'b1
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

  state_e               state;
  logic [CW-1:0]        count;
  logic [WORD_SIZE-1:0] slot [INPUT_SIZE];
  logic                 in_xfer;
  logic                 out_xfer;

  // In eFULL the buffer frees up only as the vector leaves, so ready is a
  // pass-through of the downstream ready; reset blocks the upstream outright.
  assign ready_o  = reset_i && ((state == eFILL) || ready_i);
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = (state == eFULL) && ready_i;

  assign valid_o = (state == eFULL);
  assign count_o = count;

  for (genvar k = 0; k < INPUT_SIZE; k++) begin : g_pack
    assign data_o[k*WORD_SIZE +: WORD_SIZE] = slot[k];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= eFILL;
      count <= '0;
    end else if (in_xfer) begin
      // A write in eFULL can only happen alongside the handoff (count is 0),
      // so the same wrap logic covers both the fill and the simultaneous case.
      if (count == LAST) begin
        count <= '0;
        state <= eFULL;
      end else begin
        count <= count + CW'(1);
        state <= eFILL;
      end
    end else if (out_xfer) begin
      state <= eFILL;
    end
  end

  // NOTE: the payload store is reset on purpose because data_o must read
  // zero after reset; a plain data buffer would normally be left unreset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int k = 0; k < INPUT_SIZE; k++) slot[k] <= '0;
    end else if (in_xfer) begin
      for (int k = 0; k < INPUT_SIZE; k++) begin
        if (count == CW'(k)) slot[k] <= data_i;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_blocked_write : assert property (
    @(posedge clk_i) disable iff (!reset_i) !ready_o |-> !in_xfer);

  a_hold_under_backpressure : assert property (
    @(posedge clk_i) disable iff (!reset_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(count_o)));
`endif

endmodule

// File: tb/tb_layer_deserializer.sv
// Bench for layer_deserializer: a directed vector table on the 4-word build,
// a hand sequence on the 1-word build, and random traffic on 4/1/3-word builds.
module tb_layer_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [2:0]        vi, ri, rdy, vld;
  logic [2:0][15:0]  di;
  logic [2:0][63:0]  dout;
  logic [2:0][7:0]   cnt;

  logic [63:0] d4;
  logic [15:0] d1;
  logic [47:0] d3;
  logic [1:0]  c4;
  logic        c1;
  logic [1:0]  c3;

  layer_deserializer #(.INPUT_SIZE(4), .WORD_SIZE(16)) dut4 (
    .clk_i(clk), .reset_i(rst), .valid_i(vi[0]), .ready_o(rdy[0]), .data_i(di[0]),
    .valid_o(vld[0]), .ready_i(ri[0]), .data_o(d4), .count_o(c4));

  layer_deserializer #(.INPUT_SIZE(1), .WORD_SIZE(16)) dut1 (
    .clk_i(clk), .reset_i(rst), .valid_i(vi[1]), .ready_o(rdy[1]), .data_i(di[1]),
    .valid_o(vld[1]), .ready_i(ri[1]), .data_o(d1), .count_o(c1));

  layer_deserializer #(.INPUT_SIZE(3), .WORD_SIZE(16)) dut3 (
    .clk_i(clk), .reset_i(rst), .valid_i(vi[2]), .ready_o(rdy[2]), .data_i(di[2]),
    .valid_o(vld[2]), .ready_i(ri[2]), .data_o(d3), .count_o(c3));

  assign dout[0] = d4;
  assign dout[1] = {48'h0, d1};
  assign dout[2] = {16'h0, d3};
  assign cnt[0]  = {6'h0, c4};
  assign cnt[1]  = {7'h0, c1};
  assign cnt[2]  = {6'h0, c3};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int nsize(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 3;
  endfunction

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        e_rdy;
    logic        e_vld;
    int          e_cnt;
    logic [63:0] e_data;
    logic        chk;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst_v, input logic v, input logic [15:0] d,
                              input logic r, input logic e_rdy, input logic e_vld,
                              input int e_cnt, input logic [63:0] e_data, input logic chk);
    vec_t t;
    t.rst = rst_v; t.v = v; t.d = d; t.r = r; t.e_rdy = e_rdy; t.e_vld = e_vld;
    t.e_cnt = e_cnt; t.e_data = e_data; t.chk = chk;
    tbl.push_back(t);
  endfunction

  // Reference model state for the random phase: words gathered so far and
  // the one vector waiting downstream, per build.
  int          cur_n   [3];
  logic [63:0] cur_vec [3];
  logic        exp_v   [3];
  logic [63:0] exp_vec [3];

  initial begin
    rst = 1'b0; vi = '0; ri = '0; di = '0;

    // reset, then the basic fill
    add(0, 1, 16'h5555, 1, 0, 0, 0, 64'h0, 1);
    add(1, 1, 16'h0001, 1, 1, 0, 0, 64'h0, 0);
    add(1, 1, 16'h0002, 1, 1, 0, 1, 64'h0, 0);
    add(1, 1, 16'h0003, 1, 1, 0, 2, 64'h0, 0);
    add(1, 1, 16'hFFFF, 1, 1, 0, 3, 64'h0, 0);
    add(1, 0, 16'h0000, 1, 1, 1, 0, 64'hFFFF_0003_0002_0001, 1);
    add(1, 0, 16'h0000, 1, 1, 0, 0, 64'hFFFF_0003_0002_0001, 1);
    // backpressure: vector held, then handoff with 0x1234 into slot 0
    add(1, 1, 16'h0101, 0, 1, 0, 0, 64'h0, 0);
    add(1, 1, 16'h0102, 0, 1, 0, 1, 64'h0, 0);
    add(1, 1, 16'h0103, 0, 1, 0, 2, 64'h0, 0);
    add(1, 1, 16'h0104, 0, 1, 0, 3, 64'h0, 0);
    for (int k = 0; k < 5; k++) add(1, 1, 16'h1234, 0, 0, 1, 0, 64'h0104_0103_0102_0101, 1);
    add(1, 1, 16'h1234, 1, 1, 1, 0, 64'h0104_0103_0102_0101, 1);
    add(1, 0, 16'h0000, 1, 1, 0, 1, 64'h0104_0103_0102_1234, 1);
    add(1, 1, 16'h2001, 1, 1, 0, 1, 64'h0, 0);
    add(1, 1, 16'h2002, 1, 1, 0, 2, 64'h0, 0);
    add(1, 1, 16'h2003, 1, 1, 0, 3, 64'h0, 0);
    add(1, 0, 16'h0000, 1, 1, 1, 0, 64'h2003_2002_2001_1234, 1);
    // gapped input
    add(1, 1, 16'hA000, 1, 1, 0, 0, 64'h0, 0);
    add(1, 1, 16'hA001, 1, 1, 0, 1, 64'h0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 16'hBEEF, 1, 1, 0, 2, 64'h0, 0);
    add(1, 1, 16'hA002, 1, 1, 0, 2, 64'h0, 0);
    add(1, 1, 16'hA003, 1, 1, 0, 3, 64'h0, 0);
    add(1, 0, 16'h0000, 1, 1, 1, 0, 64'hA003_A002_A001_A000, 1);
    // reset mid-vector discards the partial fill
    add(1, 1, 16'h0050, 1, 1, 0, 0, 64'h0, 0);
    add(1, 1, 16'h0051, 1, 1, 0, 1, 64'h0, 0);
    add(0, 1, 16'h0052, 1, 0, 0, 2, 64'h0, 0);
    add(1, 1, 16'h0010, 1, 1, 0, 0, 64'h0, 1);
    add(1, 1, 16'h0011, 1, 1, 0, 1, 64'h0, 0);
    add(1, 1, 16'h0012, 1, 1, 0, 2, 64'h0, 0);
    add(1, 1, 16'h0013, 1, 1, 0, 3, 64'h0, 0);
    add(1, 0, 16'h0000, 1, 1, 1, 0, 64'h0013_0012_0011_0010, 1);
    // streaming: 12 words back to back, three vectors with no bubbles
    for (int w = 0; w < 12; w++) begin
      logic [63:0] prev;
      prev = {16'(w - 1), 16'(w - 2), 16'(w - 3), 16'(w - 4)};
      if (w > 0 && w % 4 == 0) add(1, 1, 16'(w), 1, 1, 1, 0, prev, 1);
      else                     add(1, 1, 16'(w), 1, 1, 0, w % 4, 64'h0, 0);
    end
    add(1, 0, 16'h0000, 1, 1, 1, 0, 64'h000B_000A_0009_0008, 1);
    add(1, 0, 16'h0000, 1, 1, 0, 0, 64'h0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; vi[0] = tbl[i].v; di[0] = tbl[i].d; ri[0] = tbl[i].r;
      #1;
      check($sformatf("row%0d ready_o", i), 64'(rdy[0]), 64'(tbl[i].e_rdy));
      check($sformatf("row%0d valid_o", i), 64'(vld[0]), 64'(tbl[i].e_vld));
      check($sformatf("row%0d count_o", i), 64'(cnt[0]), 64'(tbl[i].e_cnt));
      if (tbl[i].chk) check($sformatf("row%0d data_o", i), dout[0], tbl[i].e_data);
    end
    @(negedge clk);
    vi[0] = 1'b0; ri[0] = 1'b0;

    // single-word build: hold under backpressure, then a simultaneous
    // handoff that keeps the block full with the new word
    vi[1] = 1'b1; di[1] = 16'hAAAA; ri[1] = 1'b0; #1;
    check("n1 empty ready_o", 64'(rdy[1]), 64'd1);
    check("n1 empty valid_o", 64'(vld[1]), 64'd0);
    @(negedge clk);
    di[1] = 16'hBBBB; #1;
    check("n1 held valid_o", 64'(vld[1]), 64'd1);
    check("n1 held ready_o", 64'(rdy[1]), 64'd0);
    check("n1 held data_o", dout[1], 64'hAAAA);
    check("n1 held count_o", 64'(cnt[1]), 64'd0);
    @(negedge clk);
    di[1] = 16'hCCCC; ri[1] = 1'b1; #1;
    check("n1 handoff ready_o", 64'(rdy[1]), 64'd1);
    check("n1 handoff data_o", dout[1], 64'hAAAA);
    @(negedge clk);
    vi[1] = 1'b0; ri[1] = 1'b0; #1;
    check("n1 refilled valid_o", 64'(vld[1]), 64'd1);
    check("n1 refilled data_o", dout[1], 64'hCCCC);

    // random traffic on all three builds against the grouping model
    @(negedge clk);
    rst = 1'b0; vi = '0; ri = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur_n[i] = 0; cur_vec[i] = '0; exp_v[i] = 1'b0; exp_vec[i] = '0;
    end

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        vi[i] = ($urandom_range(0, 3) != 0);
        ri[i] = ($urandom_range(0, 2) != 0);
        di[i] = 16'($urandom);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        logic acc;
        check($sformatf("rnd n%0d c%0d valid_o", nsize(i), cyc), 64'(vld[i]), 64'(exp_v[i]));
        check($sformatf("rnd n%0d c%0d ready_o", nsize(i), cyc), 64'(rdy[i]),
              64'(!exp_v[i] || ri[i]));
        check($sformatf("rnd n%0d c%0d count_o", nsize(i), cyc), 64'(cnt[i]), 64'(cur_n[i]));
        if (i == 2) check($sformatf("rnd n3 c%0d count below 3", cyc), 64'(cnt[2] < 8'd3), 64'd1);
        if (exp_v[i] && ri[i]) begin
          check($sformatf("rnd n%0d c%0d data_o", nsize(i), cyc), dout[i], exp_vec[i]);
          exp_v[i] = 1'b0;
          acc = vi[i];
        end else begin
          acc = vi[i] && !exp_v[i];
        end
        if (acc) begin
          cur_vec[i][cur_n[i]*16 +: 16] = di[i];
          cur_n[i]++;
          if (cur_n[i] == nsize(i)) begin
            exp_v[i]   = 1'b1;
            exp_vec[i] = cur_vec[i];
            cur_n[i]   = 0;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
